// File: rtl/uart_cmd_decoder.sv
// UART command decoder: folds received bytes, maps them to button pulses,
// toggle switches, a clear-all command and an error strobe.
module uart_cmd_decoder #(
  parameter int                     NUM_BTN      = 4,
  parameter int                     NUM_SW       = 3,
  parameter logic [8*NUM_BTN-1:0]   BTN_CODES    = 32'h6475_6C72,
  parameter logic [8*NUM_SW-1:0]    SW_CODES     = 24'h32_3130,
  parameter logic [7:0]             CLR_CODE     = 8'h7E,
  parameter int                     PULSE_CYCLES = 1,
  parameter bit                     CASE_FOLD    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic               cmd_valid,
  output logic               cmd_err,
  output logic [7:0]         last_cmd
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_FOLD && b >= 8'h41 && b <= 8'h5A)
      return b + 8'h20;
    return b;
  endfunction

  logic [7:0]         byte_q;
  logic               vld_q;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];
  logic [NUM_SW-1:0]  sw_q, sw_d;
  logic [7:0]         last_q, last_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               btn_hit, sw_hit, clr_hit, eol;
  logic [NUM_BTN-1:0] btn_sel;
  logic [NUM_SW-1:0]  sw_sel;
  logic               go_btn, go_sw, go_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= rx_done;
      if (rx_done)
        byte_q <= fold(rx_data);
    end
  end

  // Lowest-index match wins within each group
  always_comb begin
    btn_sel = '0;
    btn_hit = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!btn_hit && byte_q == BTN_CODES[8*i +: 8]) begin
        btn_sel[i] = 1'b1;
        btn_hit    = 1'b1;
      end
    end
    sw_sel = '0;
    sw_hit = 1'b0;
    for (int j = 0; j < NUM_SW; j++) begin
      if (!sw_hit && byte_q == SW_CODES[8*j +: 8]) begin
        sw_sel[j] = 1'b1;
        sw_hit    = 1'b1;
      end
    end
    clr_hit = (byte_q == CLR_CODE);
    eol     = (byte_q == 8'h0D) || (byte_q == 8'h0A);
  end

  assign go_btn = vld_q && btn_hit;
  assign go_sw  = vld_q && !btn_hit && sw_hit;
  assign go_clr = vld_q && !btn_hit && !sw_hit && clr_hit;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (go_btn && btn_sel[i])
        cnt_d[i] = CW'(PULSE_CYCLES);
      else if (cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - CW'(1);
    end
    sw_d    = sw_q;
    if (go_sw)
      sw_d = sw_q ^ sw_sel;
    else if (go_clr)
      sw_d = '0;
    valid_d = go_btn || go_sw || go_clr;
    err_d   = vld_q && !valid_d && !eol;
    last_d  = valid_d ? byte_q : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++)
        cnt_q[i] <= '0;
      sw_q    <= '0;
      last_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++)
        cnt_q[i] <= cnt_d[i];
      sw_q    <= sw_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++)
      btn_o[i] = (cnt_q[i] != '0);
  end

  assign sw_o      = sw_q;
  assign cmd_valid = valid_q;
  assign cmd_err   = err_q;
  assign last_cmd  = last_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: default build, a 4-cycle pulse
// build and a build without case folding share one input stream.
module tb_uart_cmd_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;

  logic [3:0] btn, btn4, btnnf;
  logic [2:0] sw, sw4, swnf;
  logic       vld, vld4, vldnf;
  logic       err, err4, errnf;
  logic [7:0] last, last4, lastnf;

  int total  = 0;
  int passed = 0;

  uart_cmd_decoder dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .btn_o(btn), .sw_o(sw), .cmd_valid(vld), .cmd_err(err),
    .last_cmd(last)
  );

  uart_cmd_decoder #(.PULSE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .btn_o(btn4), .sw_o(sw4), .cmd_valid(vld4), .cmd_err(err4),
    .last_cmd(last4)
  );

  uart_cmd_decoder #(.CASE_FOLD(1'b0)) dutnf (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .btn_o(btnnf), .sw_o(swnf), .cmd_valid(vldnf), .cmd_err(errnf),
    .last_cmd(lastnf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] b;
    logic [3:0] btn;
    logic [2:0] sw;
    logic       v;
    logic       e;
    logic [7:0] last;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a === e)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    rx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int run, best, hi;

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;

    tv[0]  = '{8'h72, 4'b0001, 3'b000, 1'b1, 1'b0, 8'h72};
    tv[1]  = '{8'h6C, 4'b0010, 3'b000, 1'b1, 1'b0, 8'h6C};
    tv[2]  = '{8'h55, 4'b0100, 3'b000, 1'b1, 1'b0, 8'h75};
    tv[3]  = '{8'h64, 4'b1000, 3'b000, 1'b1, 1'b0, 8'h64};
    tv[4]  = '{8'h30, 4'b0000, 3'b001, 1'b1, 1'b0, 8'h30};
    tv[5]  = '{8'h32, 4'b0000, 3'b101, 1'b1, 1'b0, 8'h32};
    tv[6]  = '{8'h78, 4'b0000, 3'b101, 1'b0, 1'b1, 8'h32};
    tv[7]  = '{8'h0D, 4'b0000, 3'b101, 1'b0, 1'b0, 8'h32};
    tv[8]  = '{8'h0A, 4'b0000, 3'b101, 1'b0, 1'b0, 8'h32};
    tv[9]  = '{8'h7E, 4'b0000, 3'b000, 1'b1, 1'b0, 8'h7E};
    tv[10] = '{8'h52, 4'b0001, 3'b000, 1'b1, 1'b0, 8'h72};
    tv[11] = '{8'h31, 4'b0000, 3'b010, 1'b1, 1'b0, 8'h31};
    tv[12] = '{8'h5B, 4'b0000, 3'b010, 1'b0, 1'b1, 8'h31};
    tv[13] = '{8'h40, 4'b0000, 3'b010, 1'b0, 1'b1, 8'h31};
    tv[14] = '{8'h44, 4'b1000, 3'b010, 1'b1, 1'b0, 8'h64};

    @(negedge clk);
    @(negedge clk);
    chk("reset_btn",  btn,  0);
    chk("reset_sw",   sw,   0);
    chk("reset_flag", {vld, err}, 0);
    chk("reset_last", last, 0);
    chk("reset_btn4", btn4, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      send(tv[i].b);
      @(negedge clk);
      chk($sformatf("v%0d_btn", i), btn, tv[i].btn);
      chk($sformatf("v%0d_sw", i), sw, tv[i].sw);
      chk($sformatf("v%0d_ve", i), {vld, err}, {tv[i].v, tv[i].e});
      chk($sformatf("v%0d_last", i), last, tv[i].last);
      @(negedge clk);
      chk($sformatf("v%0d_end", i), {btn, vld, err}, 0);
    end

    // back-to-back switch bytes, then clear
    do_reset;
    rx_data = 8'h30; rx_done = 1'b1;
    @(negedge clk);
    rx_data = 8'h30;
    @(negedge clk);
    chk("b2b_sw0", sw, 3'b001);
    rx_data = 8'h31;
    @(negedge clk);
    chk("b2b_sw1", sw, 3'b000);
    rx_done = 1'b0;
    @(negedge clk);
    chk("b2b_sw2", sw, 3'b010);
    send(8'h7E);
    @(negedge clk);
    chk("clr_sw", sw, 3'b000);
    chk("clr_valid", vld, 1'b1);

    // re-triggered stretched pulse
    do_reset;
    run = 0; best = 0; hi = 0;
    fork
      begin
        send(8'h75);
        @(negedge clk);
        send(8'h75);
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (btn4[2]) begin
            hi++;
            run++;
            if (run > best) best = run;
          end else begin
            run = 0;
          end
        end
      end
    join
    chk("pulse4_run", best, 6);
    chk("pulse4_total", hi, 6);

    // case folding on/off
    do_reset;
    send(8'h4C);
    @(negedge clk);
    chk("fold_btn", btn, 4'b0010);
    chk("fold_last", last, 8'h6C);
    chk("nofold_err", errnf, 1'b1);
    chk("nofold_btn", {btnnf, vldnf}, 0);

    // reset while a byte is in flight
    do_reset;
    send(8'h30); @(negedge clk);
    send(8'h31); @(negedge clk);
    send(8'h32); @(negedge clk);
    chk("pre_rst_sw", sw, 3'b111);
    rx_data = 8'h64; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_btn", btn, 0);
    chk("rst_sw", sw, 0);
    chk("rst_last", last, 0);
    @(negedge clk);
    chk("rst_btn_n3", {btn, vld, err}, 0);

    // rx_done coincident with reset is ignored
    rst = 1'b1; rx_data = 8'h72; rx_done = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_done = 1'b0;
    @(negedge clk);
    chk("rstrx_n1", {btn, vld, err}, 0);
    @(negedge clk);
    chk("rstrx_n2", {btn, vld, err}, 0);
    chk("rstrx_last", last, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
